// File: rtl/esc_throttle_ctrl.sv
// ESC throttle command stage. It arms the ESC by holding zero throttle with
// enable set. In RUN it slews the throttle toward a latched target at a bounded
// rate per tick. On disarm it ramps the throttle down to zero before dropping
// enable.
`timescale 1ns/1ps
module esc_throttle_ctrl #(
    parameter int unsigned TICK_DIV  = 100000,
    parameter int unsigned STEP      = 1,
    parameter int unsigned ARM_TICKS = 500,
    parameter int unsigned MAX_THR   = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arm,
    input  logic       disarm,
    input  logic [7:0] target,
    input  logic       target_valid,
    output logic [7:0] throttle,
    output logic       en,
    output logic       armed,
    output logic       at_target,
    output logic [1:0] state
);

    localparam int unsigned TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned ACW = $clog2(ARM_TICKS + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMING = 2'd1,
        S_RUN    = 2'd2,
        S_RAMPDN = 2'd3
    } state_t;

    state_t         st;
    logic [TCW-1:0] tick_cnt;
    logic           tick;
    logic [ACW-1:0] arm_cnt;
    logic [7:0]     tgt_q;
    logic [7:0]     tgt_clamp;
    logic [7:0]     tgt_next;
    logic [7:0]     step8;
    logic           up;
    logic [7:0]     diff;
    logic [7:0]     slew_amt;
    logic [7:0]     slew_thr;
    logic [7:0]     ramp_amt;
    logic [7:0]     ramp_thr;

    assign state = st;
    assign tick  = (tick_cnt == TCW'(TICK_DIV - 1));

    // Free-running slew tick divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TCW'(1);
        end
    end

    // Compute the clamped target and the next slew and ramp-down throttle values.
    // The difference is ordered, so it fits in 8 bits and cannot wrap.
    always_comb begin
        step8     = 8'(STEP);
        tgt_clamp = (target > 8'(MAX_THR)) ? 8'(MAX_THR) : target;
        tgt_next  = target_valid ? tgt_clamp : tgt_q;
        up        = (tgt_q > throttle);
        diff      = up ? (tgt_q - throttle) : (throttle - tgt_q);
        slew_amt  = (diff < step8) ? diff : step8;
        slew_thr  = up ? (throttle + slew_amt) : (throttle - slew_amt);
        ramp_amt  = (throttle < step8) ? throttle : step8;
        ramp_thr  = throttle - ramp_amt;
    end

    // Target latch; this is accepted in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_q <= 8'd0;
        end else if (target_valid) begin
            tgt_q <= tgt_clamp;
        end
    end

    // Arming, run and ramp-down sequencing, with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= S_IDLE;
            arm_cnt   <= '0;
            throttle  <= 8'd0;
            en        <= 1'b0;
            armed     <= 1'b0;
            at_target <= 1'b0;
        end else begin
            case (st)
                S_IDLE: begin
                    throttle  <= 8'd0;
                    armed     <= 1'b0;
                    at_target <= 1'b0;
                    if (arm && !disarm) begin
                        st      <= S_ARMING;
                        arm_cnt <= '0;
                        en      <= 1'b1;
                    end else begin
                        en <= 1'b0;
                    end
                end
                S_ARMING: begin
                    throttle <= 8'd0;
                    if (disarm) begin
                        st <= S_IDLE;
                        en <= 1'b0;
                    end else if (tick) begin
                        if (arm_cnt == ACW'(ARM_TICKS - 1)) begin
                            st        <= S_RUN;
                            armed     <= 1'b1;
                            at_target <= (tgt_next == 8'd0);
                        end else begin
                            arm_cnt <= arm_cnt + ACW'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (disarm) begin
                        st        <= S_RAMPDN;
                        armed     <= 1'b0;
                        at_target <= 1'b0;
                    end else if (tick) begin
                        throttle  <= slew_thr;
                        at_target <= (slew_thr == tgt_next);
                    end else begin
                        at_target <= (throttle == tgt_next);
                    end
                end
                S_RAMPDN: begin
                    if (tick) begin
                        if (throttle == 8'd0) begin
                            st <= S_IDLE;
                            en <= 1'b0;
                        end else begin
                            throttle <= ramp_thr;
                        end
                    end
                end
                default: begin
                    st <= S_IDLE;
                    en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_esc_throttle_ctrl.sv
// Bench for esc_throttle_ctrl. It runs with TICK_DIV=4, STEP=4 and ARM_TICKS=3.
// A second instance uses MAX_THR=200 for the clamp scenario.
`timescale 1ns/1ps
module tb_esc_throttle_ctrl;

    logic       clk = 1'b0;
    logic       rst, arm, disarm, target_valid;
    logic [7:0] target;
    logic [7:0] throttle, throttle2;
    logic       en, armed, at_target, en2, armed2, at_target2;
    logic [1:0] state, state2;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];

    esc_throttle_ctrl #(.TICK_DIV(4), .STEP(4), .ARM_TICKS(3), .MAX_THR(255)) u_dut (
        .clk(clk), .rst(rst), .arm(arm), .disarm(disarm), .target(target),
        .target_valid(target_valid), .throttle(throttle), .en(en), .armed(armed),
        .at_target(at_target), .state(state)
    );

    esc_throttle_ctrl #(.TICK_DIV(4), .STEP(4), .ARM_TICKS(3), .MAX_THR(200)) u_dut200 (
        .clk(clk), .rst(rst), .arm(arm), .disarm(disarm), .target(target),
        .target_valid(target_valid), .throttle(throttle2), .en(en2), .armed(armed2),
        .at_target(at_target2), .state(state2)
    );

    always #5 clk = ~clk;

    // Wait (bounded) for the throttle to move off the given value.
    task automatic wait_thr_change(input logic [7:0] last, output logic [7:0] val, output bit to);
        int n = 0;
        while (throttle === last && n < 12) begin
            @(negedge clk);
            n++;
        end
        to  = (throttle === last);
        val = throttle;
    endtask

    // Wait (bounded) for the main instance to reach a state.
    task automatic wait_state(input logic [1:0] s, input int budget, output bit to);
        int n = 0;
        while (state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        to = (state !== s);
    endtask

    task automatic pulse_target(input logic [7:0] t);
        @(negedge clk);
        target       = t;
        target_valid = 1'b1;
        @(negedge clk);
        target_valid = 1'b0;
    endtask

    task automatic pulse_arm();
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; arm = 1'b0; disarm = 1'b0; target_valid = 1'b0; target = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({throttle, en, armed, at_target, state} !== 13'd0 ||
            {throttle2, en2, armed2, at_target2, state2} !== 13'd0) begin
            $display("FAIL reset: got thr=%0d en=%b armed=%b at=%b st=%0d, expected all zero",
                     throttle, en, armed, at_target, state);
            failures++;
        end
    endtask

    task automatic test_arm();
        int  n = 0;
        bit  thr_bad = 1'b0;
        pulse_arm();
        checks++;
        if (state !== 2'd1 || en !== 1'b1 || throttle !== 8'd0) begin
            $display("FAIL arm_enter: st=%0d en=%b thr=%0d, expected st=1 en=1 thr=0", state, en, throttle);
            failures++;
        end
        while (state !== 2'd2 && n < 40) begin
            @(negedge clk);
            n++;
            if (throttle !== 8'd0) thr_bad = 1'b1;
        end
        checks++;
        if (n < 9 || n > 12) begin
            $display("FAIL arm_time: RUN after %0d clks, expected 9..12", n);
            failures++;
        end
        checks++;
        if (armed !== 1'b1 || en !== 1'b1 || thr_bad) begin
            $display("FAIL arm_run: armed=%b en=%b thr_moved=%b, expected 1 1 0", armed, en, thr_bad);
            failures++;
        end
    endtask

    task automatic test_slew_up();
        logic [7:0] last, got, e;
        bit to;
        pulse_target(8'd10);
        exp_q.push_back(8'd4); exp_q.push_back(8'd8); exp_q.push_back(8'd10);
        last = throttle;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_thr_change(last, got, to);
            checks++;
            if (to) begin
                $display("FAIL slew_up: timeout, thr=%0d expected %0d", got, e);
                failures++; exp_q.delete();
            end else if (got !== e) begin
                $display("FAIL slew_up: thr=%0d expected %0d", got, e);
                failures++;
            end
            last = got;
        end
        checks++;
        if (at_target !== 1'b1) begin
            $display("FAIL slew_up_at_target: got %b expected 1", at_target);
            failures++;
        end
        repeat (10) @(negedge clk);
        checks++;
        if (throttle !== 8'd10 || at_target !== 1'b1) begin
            $display("FAIL slew_up_hold: thr=%0d at=%b expected 10 1", throttle, at_target);
            failures++;
        end
    endtask

    task automatic test_down_and_saturate();
        logic [7:0] last, got, e;
        bit to;
        pulse_target(8'd3);
        exp_q.push_back(8'd6); exp_q.push_back(8'd3);
        last = throttle;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_thr_change(last, got, to);
            checks++;
            if (to || got !== e) begin
                $display("FAIL slew_down: thr=%0d expected %0d timeout=%b", got, e, to);
                failures++;
                if (to) exp_q.delete();
            end
            last = got;
        end
        pulse_target(8'd255);
        for (int v = 7; v <= 255; v += 4) exp_q.push_back(8'(v));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_thr_change(last, got, to);
            checks++;
            if (to || got !== e) begin
                $display("FAIL slew_sat: thr=%0d expected %0d timeout=%b", got, e, to);
                failures++;
                if (to) exp_q.delete();
            end
            last = got;
        end
        repeat (10) @(negedge clk);
        checks++;
        if (throttle !== 8'd255 || at_target !== 1'b1) begin
            $display("FAIL slew_sat_hold: thr=%0d at=%b expected 255 1", throttle, at_target);
            failures++;
        end
    endtask

    task automatic test_clamp();
        logic [7:0] last, got, e;
        bit to;
        pulse_target(8'd250);
        exp_q.push_back(8'd251); exp_q.push_back(8'd250);
        last = throttle;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_thr_change(last, got, to);
            checks++;
            if (to || got !== e) begin
                $display("FAIL clamp_main: thr=%0d expected %0d timeout=%b", got, e, to);
                failures++;
                if (to) exp_q.delete();
            end
            last = got;
        end
        repeat (8) @(negedge clk);
        checks++;
        if (throttle2 !== 8'd200 || at_target2 !== 1'b1) begin
            $display("FAIL clamp_200: thr=%0d at=%b expected 200 1", throttle2, at_target2);
            failures++;
        end
    endtask

    task automatic test_rampdown();
        logic [7:0] last, got, e;
        bit to;
        bit left = 1'b0;
        pulse_target(8'd10);
        for (int v = 246; v >= 10; v -= 4) exp_q.push_back(8'(v));
        last = throttle;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_thr_change(last, got, to);
            checks++;
            if (to || got !== e) begin
                $display("FAIL run_to_10: thr=%0d expected %0d timeout=%b", got, e, to);
                failures++;
                if (to) exp_q.delete();
            end
            last = got;
        end
        @(negedge clk);
        disarm = 1'b1;
        @(negedge clk);
        arm = 1'b1;
        checks++;
        if (state !== 2'd3 || en !== 1'b1 || throttle !== 8'd10 || armed !== 1'b0) begin
            $display("FAIL rampdn_enter: st=%0d en=%b thr=%0d armed=%b expected 3 1 10 0",
                     state, en, throttle, armed);
            failures++;
        end
        exp_q.push_back(8'd6); exp_q.push_back(8'd2); exp_q.push_back(8'd0);
        last = throttle;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_thr_change(last, got, to);
            if (state !== 2'd3) left = 1'b1;
            checks++;
            if (to || got !== e) begin
                $display("FAIL rampdn: thr=%0d expected %0d timeout=%b", got, e, to);
                failures++;
                if (to) exp_q.delete();
            end
            last = got;
        end
        checks++;
        if (left || state !== 2'd3 || en !== 1'b1) begin
            $display("FAIL rampdn_arm_ignored: st=%0d en=%b left_early=%b expected 3 1 0", state, en, left);
            failures++;
        end
        wait_state(2'd0, 8, to);
        checks++;
        if (to || en !== 1'b0 || throttle !== 8'd0) begin
            $display("FAIL rampdn_idle: st=%0d en=%b thr=%0d expected 0 0 0", state, en, throttle);
            failures++;
        end
        left = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (state !== 2'd0 || en !== 1'b0) left = 1'b1;
        end
        checks++;
        if (left) begin
            $display("FAIL idle_arm_disarm: st=%0d en=%b expected stay 0 0", state, en);
            failures++;
        end
        arm = 1'b0;
        disarm = 1'b0;
    endtask

    task automatic test_reset_mid_and_abort();
        logic [7:0] last, got, e;
        bit to;
        pulse_arm();
        wait_state(2'd2, 20, to);
        checks++;
        if (to) begin
            $display("FAIL rearm: st=%0d expected 2", state);
            failures++;
        end
        pulse_target(8'd8);
        exp_q.push_back(8'd4); exp_q.push_back(8'd8);
        last = throttle;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_thr_change(last, got, to);
            checks++;
            if (to || got !== e) begin
                $display("FAIL run_to_8: thr=%0d expected %0d timeout=%b", got, e, to);
                failures++;
                if (to) exp_q.delete();
            end
            last = got;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (throttle !== 8'd0 || en !== 1'b0 || state !== 2'd0 || armed !== 1'b0 || at_target !== 1'b0) begin
            $display("FAIL reset_mid: thr=%0d en=%b st=%0d armed=%b at=%b expected all zero",
                     throttle, en, state, armed, at_target);
            failures++;
        end
        pulse_arm();
        @(negedge clk);
        disarm = 1'b1;
        @(negedge clk);
        disarm = 1'b0;
        checks++;
        if (state !== 2'd0 || en !== 1'b0) begin
            $display("FAIL arming_abort: st=%0d en=%b expected 0 0", state, en);
            failures++;
        end
        pulse_arm();
        wait_state(2'd2, 20, to);
        repeat (9) @(negedge clk);
        checks++;
        if (to || at_target !== 1'b1 || throttle !== 8'd0) begin
            $display("FAIL tgt_cleared: st=%0d at=%b thr=%0d expected 2 1 0", state, at_target, throttle);
            failures++;
        end
    endtask

    initial begin
        test_reset();
        test_arm();
        test_slew_up();
        test_down_and_saturate();
        test_clamp();
        test_rampdown();
        test_reset_mid_and_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
